// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared traffic-light colour codes, default dwell times and monitor error indices
package semaforo_pkg;

    localparam logic [2:0] COR_VERDE    = 3'b001;
    localparam logic [2:0] COR_AMARELO  = 3'b010;
    localparam logic [2:0] COR_VERMELHO = 3'b100;

    localparam int T_VERDE    = 1;
    localparam int T_AMARELO  = 3;
    localparam int T_VERMELHO = 2;

    localparam int ERR_CODE     = 0;
    localparam int ERR_CONFLICT = 1;
    localparam int ERR_SEQ      = 2;
    localparam int ERR_TIM      = 3;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } canal_estado_t;

    function automatic logic cor_valida(input logic [2:0] c);
        return (c == COR_VERDE) || (c == COR_AMARELO) || (c == COR_VERMELHO);
    endfunction

    // Only colour that may legally follow c in the verde->amarelo->vermelho loop.
    function automatic logic [2:0] cor_seguinte(input logic [2:0] c);
        logic [2:0] s;
        case (c)
            COR_VERDE:   s = COR_AMARELO;
            COR_AMARELO: s = COR_VERMELHO;
            default:     s = COR_VERDE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/semaforo_canal_mon.sv
// rtl/semaforo_canal_mon.sv - per-light sync, sequence, dwell and cycle-count checker
// ports: clk, rst (sync active-high), cor (sampled light), valid, err_code/err_seq/err_tim (strobes for this sample), ciclos
module semaforo_canal_mon #(
    parameter int T_VERDE    = semaforo_pkg::T_VERDE,
    parameter int T_AMARELO  = semaforo_pkg::T_AMARELO,
    parameter int T_VERMELHO = semaforo_pkg::T_VERMELHO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cor,
    output logic       valid,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_tim,
    output logic [7:0] ciclos
);
    import semaforo_pkg::*;

    localparam logic [7:0] TV = T_VERDE[7:0];
    localparam logic [7:0] TA = T_AMARELO[7:0];
    localparam logic [7:0] TR = T_VERMELHO[7:0];

    canal_estado_t estado, estado_n;
    logic [2:0]    prev, prev_n;
    logic [7:0]    dwell, dwell_n;
    // [0] verde->amarelo seen, [1] amarelo->vermelho seen
    logic [1:0]    prog, prog_n;
    logic [7:0]    ciclos_n;

    assign valid = cor_valida(cor);

    always_comb begin
        estado_n = estado;
        prev_n   = prev;
        dwell_n  = dwell;
        prog_n   = prog;
        ciclos_n = ciclos;
        err_code = 1'b0;
        err_seq  = 1'b0;
        err_tim  = 1'b0;
        if (!valid) begin
            err_code = 1'b1;
            estado_n = UNSYNC;
        end else begin
            case (estado)
                UNSYNC: begin
                    estado_n = SYNC;
                    prev_n   = cor;
                    dwell_n  = 8'd1;
                    prog_n   = 2'b00;
                end
                default: begin
                    if (cor == prev) begin
                        dwell_n = (dwell == 8'hFF) ? dwell : dwell + 8'd1;
                    end else begin
                        // Dwell limits depend on the colour being left, legal change or not.
                        case (prev)
                            COR_VERDE:    err_tim = (dwell < TV);
                            COR_AMARELO:  err_tim = (dwell != TA);
                            COR_VERMELHO: err_tim = (dwell < TR);
                            default:      err_tim = 1'b0;
                        endcase
                        if (cor != cor_seguinte(prev)) begin
                            err_seq = 1'b1;
                            prog_n  = 2'b00;
                        end else if (cor == COR_AMARELO) begin
                            prog_n[0] = 1'b1;
                        end else if (cor == COR_VERMELHO) begin
                            prog_n[1] = 1'b1;
                        end else if (prog == 2'b11) begin
                            ciclos_n = ciclos + 8'd1;
                            prog_n   = 2'b00;
                        end
                        prev_n  = cor;
                        dwell_n = 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= UNSYNC;
            prev   <= COR_VERMELHO;
            dwell  <= 8'd0;
            prog   <= 2'b00;
            ciclos <= 8'd0;
        end else begin
            estado <= estado_n;
            prev   <= prev_n;
            dwell  <= dwell_n;
            prog   <= prog_n;
            ciclos <= ciclos_n;
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// rtl/semaforo_monitor.sv - passive checker of the A/B traffic-light buses
// ports: clk, rst (sync active-high), A, B (one-hot lights), err_pulse/err_sticky ([0] code [1] conflict [2] sequence [3] timing), ciclos_A, ciclos_B
module semaforo_monitor #(
    parameter int T_VERDE    = semaforo_pkg::T_VERDE,
    parameter int T_AMARELO  = semaforo_pkg::T_AMARELO,
    parameter int T_VERMELHO = semaforo_pkg::T_VERMELHO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [3:0] err_pulse,
    output logic [3:0] err_sticky,
    output logic [7:0] ciclos_A,
    output logic [7:0] ciclos_B
);
    import semaforo_pkg::*;

    logic       valid_a, code_a, seq_a, tim_a;
    logic       valid_b, code_b, seq_b, tim_b;
    logic [3:0] err_n;

    semaforo_canal_mon #(
        .T_VERDE    (T_VERDE),
        .T_AMARELO  (T_AMARELO),
        .T_VERMELHO (T_VERMELHO)
    ) u_canal_a (
        .clk      (clk),
        .rst      (rst),
        .cor      (A),
        .valid    (valid_a),
        .err_code (code_a),
        .err_seq  (seq_a),
        .err_tim  (tim_a),
        .ciclos   (ciclos_A)
    );

    semaforo_canal_mon #(
        .T_VERDE    (T_VERDE),
        .T_AMARELO  (T_AMARELO),
        .T_VERMELHO (T_VERMELHO)
    ) u_canal_b (
        .clk      (clk),
        .rst      (rst),
        .cor      (B),
        .valid    (valid_b),
        .err_code (code_b),
        .err_seq  (seq_b),
        .err_tim  (tim_b),
        .ciclos   (ciclos_B)
    );

    always_comb begin
        err_n               = 4'b0000;
        err_n[ERR_CODE]     = code_a | code_b;
        // Conflict ignores sync state: any two valid non-red lights collide.
        err_n[ERR_CONFLICT] = valid_a && valid_b && (A != COR_VERMELHO) && (B != COR_VERMELHO);
        err_n[ERR_SEQ]      = seq_a | seq_b;
        err_n[ERR_TIM]      = tim_a | tim_b;
    end

    // Sticky includes the pulse of the same sample so both rise on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 4'b0000;
            err_sticky <= 4'b0000;
        end else begin
            err_pulse  <= err_n;
            err_sticky <= err_sticky | err_n;
        end
    end

endmodule

// File: tb/tb_semaforo_monitor.sv
// tb/tb_semaforo_monitor.sv - self-checking bench for semaforo_monitor
module tb_semaforo_monitor;

    localparam int TV = 1;
    localparam int TA = 3;
    localparam int TR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] A = 3'b001;
    logic [2:0] B = 3'b100;
    logic [3:0] err_pulse, err_sticky;
    logic [7:0] ciclos_A, ciclos_B;

    int errors = 0;
    int checks = 0;

    // Reference model: colours as 0 verde, 1 amarelo, 2 vermelho, -1 invalid.
    bit         m_sync [2];
    int         m_prev [2];
    int         m_dwell[2];
    bit         m_va   [2];
    bit         m_av   [2];
    int         m_cyc  [2];
    logic [3:0] m_pulse;
    logic [3:0] m_sticky;

    always #5 clk = ~clk;

    semaforo_monitor #(
        .T_VERDE    (TV),
        .T_AMARELO  (TA),
        .T_VERMELHO (TR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .ciclos_A   (ciclos_A),
        .ciclos_B   (ciclos_B)
    );

    function automatic int colour_of(input logic [2:0] c);
        if (c === 3'b001) return 0;
        if (c === 3'b010) return 1;
        if (c === 3'b100) return 2;
        return -1;
    endfunction

    task automatic model_step(input bit r, input logic [2:0] a, input logic [2:0] b);
        int c;
        int lim_ok;
        m_pulse = 4'b0000;
        if (r) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_sync[ch] = 0; m_dwell[ch] = 0; m_va[ch] = 0; m_av[ch] = 0; m_cyc[ch] = 0;
            end
            m_sticky = 4'b0000;
            return;
        end
        if (colour_of(a) >= 0 && colour_of(b) >= 0 && colour_of(a) != 2 && colour_of(b) != 2)
            m_pulse[1] = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
            c = (ch == 0) ? colour_of(a) : colour_of(b);
            if (c < 0) begin
                m_pulse[0] = 1'b1;
                m_sync[ch] = 0;
            end else if (!m_sync[ch]) begin
                m_sync[ch] = 1; m_prev[ch] = c; m_dwell[ch] = 1; m_va[ch] = 0; m_av[ch] = 0;
            end else if (c == m_prev[ch]) begin
                m_dwell[ch] = (m_dwell[ch] >= 255) ? 255 : m_dwell[ch] + 1;
            end else begin
                if (m_prev[ch] == 0)      lim_ok = (m_dwell[ch] >= TV);
                else if (m_prev[ch] == 1) lim_ok = (m_dwell[ch] == TA);
                else                      lim_ok = (m_dwell[ch] >= TR);
                if (!lim_ok) m_pulse[3] = 1'b1;
                if (c != (m_prev[ch] + 1) % 3) begin
                    m_pulse[2] = 1'b1; m_va[ch] = 0; m_av[ch] = 0;
                end else if (c == 1) begin
                    m_va[ch] = 1;
                end else if (c == 2) begin
                    m_av[ch] = 1;
                end else if (m_va[ch] && m_av[ch]) begin
                    m_cyc[ch] = (m_cyc[ch] + 1) % 256; m_va[ch] = 0; m_av[ch] = 0;
                end
                m_prev[ch] = c;
                m_dwell[ch] = 1;
            end
        end
        m_sticky = m_sticky | m_pulse;
    endtask

    task automatic drive(input bit r, input logic [2:0] a, input logic [2:0] b);
        rst = r; A = a; B = b;
        @(posedge clk);
        model_step(r, a, b);
        #1;
    endtask

    function automatic logic [2:0] gen_code(input logic [2:0] cur);
        logic [2:0] bad [5];
        int r;
        int c;
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        r = $urandom_range(0, 99);
        c = colour_of(cur);
        if (r < 65) return cur;
        if (r < 88) return (c < 0) ? 3'b001 : 3'(1 << ((c + 1) % 3));
        if (r < 95) return 3'(1 << $urandom_range(0, 2));
        return bad[$urandom_range(0, 4)];
    endfunction

    task automatic test_reset();
        drive(1, 3'b001, 3'b100);
        checks++;
        if ({err_pulse, err_sticky, ciclos_A, ciclos_B} !== 24'h0) begin
            errors++;
            $display("FAIL reset: got pulse=%b sticky=%b cA=%0d cB=%0d, expected all 0", err_pulse, err_sticky, ciclos_A, ciclos_B);
        end
    endtask

    task automatic test_legal();
        logic [2:0] sa [11] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        logic [2:0] sb [11] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
        drive(1, 3'b001, 3'b100);
        for (int i = 0; i < 11; i++) begin
            drive(0, sa[i], sb[i]);
            checks++;
            if ({err_pulse, err_sticky, ciclos_A, ciclos_B} !== {m_pulse, m_sticky, 8'(m_cyc[0]), 8'(m_cyc[1])}) begin
                errors++;
                $display("FAIL legal step %0d: got %b %b %0d %0d, expected %b %b %0d %0d", i,
                         err_pulse, err_sticky, ciclos_A, ciclos_B, m_pulse, m_sticky, m_cyc[0], m_cyc[1]);
            end
        end
        checks++;
        if (err_sticky !== 4'b0000 || ciclos_A !== 8'd1) begin
            errors++;
            $display("FAIL legal final: got sticky=%b cA=%0d, expected sticky=0000 cA=1", err_sticky, ciclos_A);
        end
    endtask

    task automatic test_yellow_short();
        drive(1, 3'b001, 3'b100);
        drive(0, 3'b001, 3'b100);
        drive(0, 3'b010, 3'b100);
        drive(0, 3'b010, 3'b100);
        drive(0, 3'b100, 3'b100);
        checks++;
        if (err_pulse !== 4'b1000 || err_pulse !== m_pulse) begin
            errors++;
            $display("FAIL yellow_short pulse: got %b, expected 1000 (model %b)", err_pulse, m_pulse);
        end
        drive(0, 3'b100, 3'b100);
        checks++;
        if (err_pulse !== 4'b0000 || err_sticky !== 4'b1000) begin
            errors++;
            $display("FAIL yellow_short after: got pulse=%b sticky=%b, expected 0000 1000", err_pulse, err_sticky);
        end
    endtask

    task automatic test_illegal_seq();
        drive(1, 3'b001, 3'b100);
        drive(0, 3'b001, 3'b100);
        drive(0, 3'b100, 3'b100);
        checks++;
        if (err_pulse !== 4'b0100) begin
            errors++;
            $display("FAIL illegal_seq pulse: got %b, expected 0100", err_pulse);
        end
        drive(0, 3'b100, 3'b100);
        drive(0, 3'b001, 3'b100);
        checks++;
        if (err_pulse !== 4'b0000 || ciclos_A !== 8'd0 || m_cyc[0] != 0) begin
            errors++;
            $display("FAIL illegal_seq return: got pulse=%b cA=%0d, expected 0000 0", err_pulse, ciclos_A);
        end
    endtask

    task automatic test_conflict();
        logic [2:0] sa [5] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
        logic [2:0] sb [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
        logic [3:0] want [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        drive(1, 3'b001, 3'b100);
        for (int i = 0; i < 5; i++) begin
            drive(0, sa[i], sb[i]);
            checks++;
            if (err_pulse !== want[i] || err_pulse !== m_pulse) begin
                errors++;
                $display("FAIL conflict step %0d: got %b, expected %b (model %b)", i, err_pulse, want[i], m_pulse);
            end
        end
        checks++;
        if (err_sticky !== 4'b0010) begin
            errors++;
            $display("FAIL conflict sticky: got %b, expected 0010", err_sticky);
        end
    endtask

    task automatic test_bad_code();
        logic [2:0] sa [6] = '{3'b001, 3'b011, 3'b010, 3'b010, 3'b010, 3'b100};
        logic [3:0] want [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        drive(1, 3'b001, 3'b100);
        for (int i = 0; i < 6; i++) begin
            drive(0, sa[i], 3'b100);
            checks++;
            if (err_pulse !== want[i] || err_pulse !== m_pulse) begin
                errors++;
                $display("FAIL bad_code step %0d: got %b, expected %b (model %b)", i, err_pulse, want[i], m_pulse);
            end
        end
        checks++;
        if (err_sticky !== 4'b0001) begin
            errors++;
            $display("FAIL bad_code sticky: got %b, expected 0001", err_sticky);
        end
    endtask

    task automatic test_saturation();
        drive(1, 3'b001, 3'b100);
        drive(0, 3'b001, 3'b100);
        repeat (300) drive(0, 3'b010, 3'b100);
        drive(0, 3'b100, 3'b100);
        checks++;
        if (err_pulse !== 4'b1000) begin
            errors++;
            $display("FAIL saturation: got %b, expected 1000", err_pulse);
        end
    endtask

    task automatic test_wrap_reset();
        drive(1, 3'b001, 3'b100);
        drive(0, 3'b001, 3'b100);
        for (int n = 1; n <= 256; n++) begin
            repeat (3) drive(0, 3'b010, 3'b100);
            repeat (2) drive(0, 3'b100, 3'b100);
            drive(0, 3'b001, 3'b100);
            checks++;
            if (ciclos_A !== 8'(n % 256) || err_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL wrap cycle %0d: got cA=%0d pulse=%b, expected cA=%0d pulse=0000", n, ciclos_A, err_pulse, n % 256);
            end
        end
        drive(0, 3'b010, 3'b100);
        drive(1, 3'b010, 3'b100);
        checks++;
        if ({err_pulse, err_sticky, ciclos_A, ciclos_B} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: got %b %b %0d %0d, expected all 0", err_pulse, err_sticky, ciclos_A, ciclos_B);
        end
        drive(0, 3'b010, 3'b100);
        checks++;
        if (err_pulse !== 4'b0000 || err_sticky !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset: got pulse=%b sticky=%b, expected 0000 0000", err_pulse, err_sticky);
        end
    endtask

    task automatic test_random();
        logic [2:0] ra, rb;
        bit r;
        ra = 3'b001; rb = 3'b100;
        drive(1, ra, rb);
        for (int i = 0; i < 1500; i++) begin
            ra = gen_code(ra);
            rb = gen_code(rb);
            r  = ($urandom_range(0, 99) == 0);
            drive(r, ra, rb);
            checks++;
            if ({err_pulse, err_sticky, ciclos_A, ciclos_B} !== {m_pulse, m_sticky, 8'(m_cyc[0]), 8'(m_cyc[1])}) begin
                errors++;
                $display("FAIL random step %0d A=%b B=%b rst=%0d: got %b %b %0d %0d, expected %b %b %0d %0d", i, ra, rb, r,
                         err_pulse, err_sticky, ciclos_A, ciclos_B, m_pulse, m_sticky, m_cyc[0], m_cyc[1]);
            end
        end
    endtask

    task automatic test_random_legal();
        int da, db;
        drive(1, 3'b001, 3'b100);
        for (int n = 0; n < 20; n++) begin
            da = $urandom_range(1, 4);
            db = $urandom_range(2, 5);
            repeat (da) drive(0, 3'b001, 3'b100);
            repeat (TA) drive(0, 3'b010, 3'b100);
            repeat (db) drive(0, 3'b100, 3'b100);
            checks++;
            if ({err_pulse, err_sticky, ciclos_A} !== {m_pulse, m_sticky, 8'(m_cyc[0])} || err_sticky !== 4'b0000) begin
                errors++;
                $display("FAIL random_legal lap %0d: got %b %b %0d, expected %b %b %0d", n,
                         err_pulse, err_sticky, ciclos_A, m_pulse, m_sticky, m_cyc[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_yellow_short();
        test_illegal_seq();
        test_conflict();
        test_bad_code();
        test_saturation();
        test_wrap_reset();
        test_random_legal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
